flexbus_regbank: RTL

Parametrised FlexBus slave register bank: the next-generation successor to the fixed five-register `perip_flexbus` peripheral. It decodes a 4 KiB window of the multiplexed FlexBus address/data bus and exposes `NUM_RW` read/write registers with per-register write strobes, plus `NUM_RO` read-only status words. It sits between the MCU FlexBus pins and the PL peripherals, such as the LED/PWM and buzzer frequency generators.

---
 rtl/flexbus_regbank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/flexbus_regbank.sv
// FlexBus slave register bank: NUM_RW read/write registers plus NUM_RO status words in a 4 KiB window.
// Optional `FB_TA_EN: data-phase wait states and a one-cycle FB_TA_n acknowledge.
module flexbus_regbank #(
  parameter logic [31:0] FB_BASE     = 32'h6000_0000,
  parameter int          NUM_RW      = 8,
  parameter int          NUM_RO      = 2,
  parameter int          WAIT_STATES = 0,
  localparam int         RO_W        = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                FB_CLK,
  input  logic                RST_n,
  input  logic                FB_ALE,
  input  logic                FB_CS,
  input  logic                FB_RW,
  inout  wire  [31:0]         FB_AD,
  output logic                FB_TA_n,
  output logic [32*NUM_RW-1:0] REG_Qout,
  output logic [NUM_RW-1:0]   REG_WSTB,
  input  logic [32*RO_W-1:0]  STATUS_Din
);

  typedef enum logic [1:0] {IDLE, ARMED, DATA, DONE} state_t;

  state_t                   state, state_nxt;
  logic [9:0]               idx_q;
  logic                     rd_q;
  logic [31:0]              rdata_q, rdata_sel;
  logic [3:0]               cnt;
  logic                     hit, complete, cnt_load, cnt_dec, drive, wr_ok;
  logic [NUM_RW-1:0][31:0]  regs;
  logic                     wr_pend;
  logic [9:0]               wr_idx;
  logic [31:0]              wr_data;
  logic [NUM_RW-1:0]        wsel;

  assign hit   = (FB_AD[31:12] == FB_BASE[31:12]);
  assign wr_ok = ({22'd0, idx_q} < 32'(NUM_RW));
  assign REG_Qout = regs;

  // Read data is chosen from the live address so it can be snapshotted on the ALE edge.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (FB_AD[11:2] == 10'(i)) rdata_sel = regs[i];
    for (int j = 0; j < NUM_RO; j++)
      if (FB_AD[11:2] == 10'(NUM_RW + j)) rdata_sel = STATUS_Din[32*j +: 32];
  end

  always_ff @(posedge FB_CLK or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;

  // ALE has priority in every state and restarts decode.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (FB_ALE) begin
      state_nxt = hit ? ARMED : IDLE;
    end else begin
      case (state)
        ARMED: if (!FB_CS) begin
`ifdef FB_TA_EN
          state_nxt = DATA;
          cnt_load  = 1'b1;
`else
          state_nxt = DONE;
          complete  = 1'b1;
`endif
        end
        DATA: begin
          if (FB_CS)             state_nxt = IDLE;
          else if (cnt != 4'd0)  cnt_dec   = 1'b1;
          else begin
            state_nxt = DONE;
            complete  = 1'b1;
          end
        end
        DONE:    if (FB_CS) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  // Write path: sample on completion, update register next edge, strobe the edge after.
  always_ff @(posedge FB_CLK or negedge RST_n)
    if (!RST_n) begin
      idx_q    <= '0;
      rd_q     <= 1'b0;
      rdata_q  <= '0;
      cnt      <= '0;
      wr_pend  <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
      wsel     <= '0;
      regs     <= '0;
      REG_WSTB <= '0;
    end else begin
      if (FB_ALE) begin
        idx_q   <= FB_AD[11:2];
        rd_q    <= FB_RW;
        rdata_q <= rdata_sel;
      end
      if (cnt_load)     cnt <= 4'(WAIT_STATES);
      else if (cnt_dec) cnt <= cnt - 4'd1;
      wr_pend <= complete && !rd_q && wr_ok;
      if (complete) begin
        wr_idx  <= idx_q;
        wr_data <= FB_AD;
      end
      wsel <= '0;
      for (int i = 0; i < NUM_RW; i++)
        if (wr_pend && wr_idx == 10'(i)) begin
          regs[i] <= wr_data;
          wsel[i] <= 1'b1;
        end
      REG_WSTB <= wsel;
    end

  // CS term is combinational so the bus releases in the cycle CS rises.
  assign drive = (state == DATA || state == DONE) && rd_q && !FB_CS;
  assign FB_AD = drive ? rdata_q : 32'hz;

`ifdef FB_TA_EN
  logic ta_q;
  always_ff @(posedge FB_CLK or negedge RST_n)
    if (!RST_n) ta_q <= 1'b1;
    else        ta_q <= ~complete;
  assign FB_TA_n = ta_q;
`else
  assign FB_TA_n = 1'b1;
`endif

endmodule
